// File: rtl/dispatch_unit.sv
// Dispatch control between the IFQ head and the ROB/RS/RAT write ports.
// Issues at most one instruction per cycle, gated only by reset readiness and the full flags.
module dispatch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic        rs1_valid,
  input  logic        rs2_valid,
  input  logic [4:0]  rs1_tag,
  input  logic [4:0]  rs2_tag,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic [4:0]  rob_tail,
  input  logic [2:0]  rs_slot,
  output logic        rob_we,
  output logic        rs_we,
  output logic        rat_we,
  output logic        ifq_rd_en,
  output logic        stall
);

  logic ready_q;
  logic go;

  // Operand and context fields travel straight to the ROB/RS/RAT; dispatch
  // control never looks at them, so X operands cannot leak into the enables.
  logic unused_operands;
  assign unused_operands = ^{instruction, pc, rs1_valid, rs2_valid, rs1_tag,
                             rs2_tag, rs1_val, rs2_val, rob_tail, rs_slot};

  // rst is active-low; clearing is asynchronous so dispatch dies mid-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    go        = 1'b0;
    rob_we    = 1'b0;
    rs_we     = 1'b0;
    rat_we    = 1'b0;
    ifq_rd_en = 1'b0;
    stall     = 1'b1;

    go = ready_q & ~rob_full & ~rs_full;
    if (go) begin
      rob_we    = 1'b1;
      rs_we     = 1'b1;
      rat_we    = 1'b1;
      ifq_rd_en = 1'b1;
      stall     = 1'b0;
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: reset behaviour, full-flag gating and
// asynchronous mid-cycle reset, checked on the packed output vector.
`timescale 1ns/100ps
module tb_dispatch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        rs1_valid;
  logic        rs2_valid;
  logic [4:0]  rs1_tag;
  logic [4:0]  rs2_tag;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        rob_full;
  logic        rs_full;
  logic [4:0]  rob_tail;
  logic [2:0]  rs_slot;
  logic        rob_we;
  logic        rs_we;
  logic        rat_we;
  logic        ifq_rd_en;
  logic        stall;

  int n_cmp;
  int n_bad;

  // {rob_we, rs_we, rat_we, ifq_rd_en, stall}
  localparam logic [4:0] STALLED  = 5'b00001;
  localparam logic [4:0] DISPATCH = 5'b11110;

  dispatch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc          (pc),
    .rs1_valid   (rs1_valid),
    .rs2_valid   (rs2_valid),
    .rs1_tag     (rs1_tag),
    .rs2_tag     (rs2_tag),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rob_full    (rob_full),
    .rs_full     (rs_full),
    .rob_tail    (rob_tail),
    .rs_slot     (rs_slot),
    .rob_we      (rob_we),
    .rs_we       (rs_we),
    .rat_we      (rat_we),
    .ifq_rd_en   (ifq_rd_en),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (rob_we,rs_we,rat_we,ifq_rd_en,stall)", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {rob_we, rs_we, rat_we, ifq_rd_en, stall};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst         = 1'b0;
    rob_full    = 1'b0;
    rs_full     = 1'b0;
    instruction = 'x;
    pc          = 'x;
    rs1_valid   = 1'bx;
    rs2_valid   = 1'bx;
    rs1_tag     = 'x;
    rs2_tag     = 'x;
    rs1_val     = 'x;
    rs2_val     = 'x;
    rob_tail    = 'x;
    rs_slot     = 'x;

    #3;
    check_out("reset_hold", outs(), STALLED);
    @(posedge clk); #1;
    check_out("reset_hold_after_edge", outs(), STALLED);
    @(posedge clk); #1;
    check_out("reset_hold_after_edge2", outs(), STALLED);

    // Release between edges: nothing may dispatch until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("release_before_edge", outs(), STALLED);
    @(posedge clk); #1;
    check_out("first_dispatch", outs(), DISPATCH);

    rob_full = 1'b1; #1;
    check_out("rob_full", outs(), STALLED);
    rob_full = 1'b0; rs_full = 1'b1; #1;
    check_out("rs_full", outs(), STALLED);
    rob_full = 1'b1; rs_full = 1'b1; #1;
    check_out("both_full", outs(), STALLED);
    rob_full = 1'b0; rs_full = 1'b0; #1;
    check_out("both_clear", outs(), DISPATCH);

    // Sustained dispatch across edges with varied operand context.
    for (int i = 0; i < 3; i++) begin
      instruction = 32'h0000_0033 + i;
      pc          = 32'h1000 + 4 * i;
      rs1_valid   = i[0];
      rs2_valid   = ~i[0];
      rs1_tag     = 5'(i * 7);
      rs2_tag     = 5'(31 - i);
      rs1_val     = 32'hDEAD_0000 + i;
      rs2_val     = 32'hBEEF_0000 + i;
      rob_tail    = 5'(i + 3);
      rs_slot     = 3'(i);
      @(posedge clk); #1;
      check_out($sformatf("steady_dispatch_%0d", i), outs(), DISPATCH);
    end

    // Full flag rising just after an edge blocks within that same cycle.
    @(posedge clk); #2;
    rs_full = 1'b1; #1;
    check_out("rs_full_midcycle", outs(), STALLED);
    @(posedge clk); #1;
    check_out("rs_full_held", outs(), STALLED);
    rs_full = 1'b0; #1;
    check_out("rs_full_drop", outs(), DISPATCH);

    // Asynchronous reset between edges, released before the next edge.
    @(negedge clk); #1;
    rst = 1'b0; #1;
    check_out("async_reset_midcycle", outs(), STALLED);
    rst = 1'b1; #1;
    check_out("rerelease_before_edge", outs(), STALLED);
    @(posedge clk); #1;
    check_out("redispatch_after_edge", outs(), DISPATCH);

    // Full flags while held in reset must not produce any enable.
    rst = 1'b0; rob_full = 1'b1; #1;
    check_out("reset_with_rob_full", outs(), STALLED);
    rob_full = 1'b0; #1;
    check_out("reset_flags_clear", outs(), STALLED);
    rst = 1'b1;
    @(posedge clk); #1;
    check_out("final_dispatch", outs(), DISPATCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
